// File: rtl/divider_seq_8by4_pkg.sv
// Shared widths and FSM encoding for the sequential 8-by-4 restoring divider.
package divider_seq_8by4_pkg;

    localparam int DVD_W = 8;
    localparam int DVS_W = 4;
    localparam int CNT_W = $clog2(DVD_W);

    // state   | meaning
    // ST_IDLE | waiting for start, results held
    // ST_RUN  | one restoring step per clock, counter DVD_W-1 down to 0
    // ST_FIN  | results written to outputs, done pulsed; start accepted as in idle
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

endpackage

// File: rtl/divider_seq_8by4_if.sv
// Start/result handshake bundle between a requester and the divider.
interface divider_seq_8by4_if;
    import divider_seq_8by4_pkg::*;

    logic             start;
    logic [DVD_W-1:0] dividend;
    logic [DVS_W-1:0] divisor;
    logic             busy;
    logic             done;
    logic [DVD_W-1:0] quotient;
    logic [DVS_W-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/divider_seq_8by4_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module divider_seq_8by4_step
    import divider_seq_8by4_pkg::*;
(
    input  logic [DVS_W:0]   p_in,
    input  logic             bit_in,
    input  logic [DVS_W-1:0] divisor,
    output logic [DVS_W:0]   p_out,
    output logic             q_bit
);

    logic [DVS_W:0] p_shift;

    // P' = {P[DVS_W-1:0], bit}; keep the difference only when it does not go negative.
    always_comb begin
        p_shift = (DVS_W+1)'({p_in, bit_in});
        p_out   = p_shift;
        q_bit   = 1'b0;
        if (p_shift >= {1'b0, divisor}) begin
            p_out = p_shift - {1'b0, divisor};
            q_bit = 1'b1;
        end
    end

endmodule

// File: rtl/divider_seq_8by4.sv
// Sequential unsigned divider, one quotient bit per clock, with start/busy/done handshake.
module divider_seq_8by4
    import divider_seq_8by4_pkg::*;
(
    input logic              clk,
    input logic              rst_n,
    divider_seq_8by4_if.slave bus
);

    state_t           state;
    logic [DVD_W-1:0] q_reg;
    logic [DVS_W:0]   p_reg;
    logic [DVS_W-1:0] dvs_reg;
    logic [CNT_W-1:0] cnt;
    logic             dbz_reg;

    logic [DVS_W:0]   p_next;
    logic             q_bit;
    logic             accept;

    assign accept = bus.start && (state == ST_IDLE || state == ST_FIN);

    divider_seq_8by4_step u_step (
        .p_in    (p_reg),
        .bit_in  (q_reg[DVD_W-1]),
        .divisor (dvs_reg),
        .p_out   (p_next),
        .q_bit   (q_bit)
    );

    // FSM, datapath registers and registered outputs; an accepted start overrides the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            q_reg           <= '0;
            p_reg           <= '0;
            dvs_reg         <= '0;
            cnt             <= '0;
            dbz_reg         <= 1'b0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.quotient    <= '0;
            bus.remainder   <= '0;
            bus.div_by_zero <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                ST_IDLE: ;
                ST_RUN: begin
                    p_reg <= p_next;
                    q_reg <= {q_reg[DVD_W-2:0], q_bit};
                    if (cnt == '0) begin
                        state    <= ST_FIN;
                        bus.busy <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_FIN: begin
                    bus.done        <= 1'b1;
                    bus.div_by_zero <= dbz_reg;
                    if (dbz_reg) begin
                        // q_reg still holds the untouched dividend on this path
                        bus.quotient  <= '1;
                        bus.remainder <= DVS_W'(q_reg);
                    end else begin
                        bus.quotient  <= q_reg;
                        bus.remainder <= DVS_W'(p_reg);
                    end
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase

            if (accept) begin
                q_reg   <= bus.dividend;
                p_reg   <= '0;
                dvs_reg <= bus.divisor;
                cnt     <= CNT_W'(DVD_W - 1);
                dbz_reg <= (bus.divisor == '0);
                if (bus.divisor == '0) begin
                    state    <= ST_FIN;
                    bus.busy <= 1'b0;
                end else begin
                    state    <= ST_RUN;
                    bus.busy <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_divider_seq_8by4.sv
// Directed and randomised checks of the sequential divider against hand-computed and / % results.
module tb_divider_seq_8by4;
    import divider_seq_8by4_pkg::*;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_pass;
    int   done_seen;
    int   done_exp;
    logic [DVD_W-1:0] hold_q;
    logic [DVS_W-1:0] hold_r;
    logic             hold_dbz;

    divider_seq_8by4_if bus ();

    divider_seq_8by4 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // done pulses counted away from the active edge
    always @(negedge clk) if (bus.done === 1'b1) done_seen++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // One division; optional stray start (99/9) pulsed glitch_at cycles into the run.
    task automatic run_div(input logic [7:0] a, input logic [3:0] b,
                           input logic [7:0] eq, input logic [3:0] er, input logic edbz,
                           input int glitch_at);
        int cnt;
        bus.dividend = a;
        bus.divisor  = b;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        cnt = 0;
        chk("busy_after_start", bus.busy, (b != 0));
        chk("hold_q", bus.quotient, hold_q);
        chk("hold_r", bus.remainder, hold_r);
        chk("hold_dbz", bus.div_by_zero, hold_dbz);
        while (bus.done !== 1'b1 && cnt < 40) begin
            if (cnt == glitch_at) begin
                bus.start    = 1'b1;
                bus.dividend = 8'd99;
                bus.divisor  = 4'd9;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            cnt++;
        end
        bus.start = 1'b0;
        chk("latency", cnt, (b == 0) ? 1 : 9);
        chk("quotient", bus.quotient, eq);
        chk("remainder", bus.remainder, er);
        chk("div_by_zero", bus.div_by_zero, edbz);
        done_exp++;
        @(negedge clk);
        chk("done_one_cycle", bus.done, 1'b0);
        chk("busy_idle", bus.busy, 1'b0);
        hold_q   = eq;
        hold_r   = er;
        hold_dbz = edbz;
    endtask

    initial begin
        logic [7:0] a, na, eq;
        logic [3:0] b, nb, er;
        logic       btb;
        int         cnt, lat, acc0, seen0;

        n_chk = 0; n_pass = 0; done_seen = 0; done_exp = 0;
        hold_q = '0; hold_r = '0; hold_dbz = 1'b0;
        bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_quotient", bus.quotient, 8'd0);
        chk("rst_remainder", bus.remainder, 4'd0);
        chk("rst_dbz", bus.div_by_zero, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        run_div(8'd200, 4'd7, 8'd28, 4'd4, 1'b0, -1);
        run_div(8'd255, 4'd1, 8'd255, 4'd0, 1'b0, -1);
        run_div(8'd255, 4'd15, 8'd17, 4'd0, 1'b0, -1);
        run_div(8'd5, 4'd9, 8'd0, 4'd5, 1'b0, -1);
        run_div(8'd0, 4'd3, 8'd0, 4'd0, 1'b0, -1);
        run_div(8'd123, 4'd0, 8'd255, 4'd11, 1'b1, -1);
        run_div(8'd10, 4'd3, 8'd3, 4'd1, 1'b0, -1);
        run_div(8'd200, 4'd7, 8'd28, 4'd4, 1'b0, 3);
        repeat (12) @(negedge clk);
        chk("done_count_directed", done_seen, done_exp);

        // reset in the middle of a run aborts it without a done
        bus.dividend = 8'd200; bus.divisor = 4'd7; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_quotient", bus.quotient, 8'd0);
        chk("midrst_remainder", bus.remainder, 4'd0);
        chk("midrst_dbz", bus.div_by_zero, 1'b0);
        chk("midrst_busy", bus.busy, 1'b0);
        chk("midrst_done", bus.done, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("done_count_after_reset", done_seen, done_exp);
        hold_q = '0; hold_r = '0; hold_dbz = 1'b0;
        run_div(8'd45, 4'd6, 8'd7, 4'd3, 1'b0, -1);

        // random pairs, some issued back-to-back while the previous one is in FIN
        acc0 = 0; seen0 = done_seen;
        a = 8'($urandom); b = 4'($urandom);
        bus.dividend = a; bus.divisor = b; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; acc0++; cnt = 0;
        for (int k = 0; k < 1000; k++) begin
            lat = (b == 0) ? 1 : 9;
            btb = (k < 999) && ($urandom_range(0, 1) == 1);
            while (cnt < lat - 1) begin
                @(negedge clk);
                cnt++;
            end
            if (btb) begin
                na = 8'($urandom); nb = 4'($urandom);
                bus.dividend = na; bus.divisor = nb; bus.start = 1'b1;
            end
            @(negedge clk);
            bus.start = 1'b0;
            if (b == 0) begin
                eq = 8'hFF; er = a[3:0];
            end else begin
                eq = a / b; er = 4'(a % b);
            end
            chk("rnd_done", bus.done, 1'b1);
            chk("rnd_quotient", bus.quotient, eq);
            chk("rnd_remainder", bus.remainder, er);
            chk("rnd_dbz", bus.div_by_zero, (b == 0));
            if (btb) begin
                a = na; b = nb; acc0++; cnt = 0;
            end else if (k < 999) begin
                a = 8'($urandom); b = 4'($urandom);
                repeat ($urandom_range(0, 2)) @(negedge clk);
                bus.dividend = a; bus.divisor = b; bus.start = 1'b1;
                @(negedge clk);
                bus.start = 1'b0; acc0++; cnt = 0;
            end
        end
        repeat (12) @(negedge clk);
        chk("rnd_done_count", done_seen - seen0, acc0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
